// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//   Shares the single register-file write port between the ALU writeback
//   (req0) and the load writeback (req1) using round-robin arbitration over
//   valid/ready handshakes. Drives a registered write port into the bank and
//   keeps a pending-write scoreboard for issue-stage hazard detection.
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   reqValid0/reqAddr0/reqData0     ALU writeback request
//   reqReady0                       ALU request accepted this cycle
//   reqValid1/reqAddr1/reqData1     load writeback request
//   reqReady1                       load request accepted this cycle
//   resvEn/resvAddr                 issue stage reserves a destination register
//   writeEn/writeAddr/writeData     registered register-file write port
//   busyMask                        bit r set while a write to r is pending
//   resvConflict                    one-cycle pulse: reservation hit a busy register
module regfile_write_arbiter #(
    parameter int BIT_WIDTH  = 32,
    parameter int ADDR_WIDTH = 5,
    localparam int NREG      = 2 ** ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  reqValid0,
    input  logic [ADDR_WIDTH-1:0] reqAddr0,
    input  logic [BIT_WIDTH-1:0]  reqData0,
    output logic                  reqReady0,
    input  logic                  reqValid1,
    input  logic [ADDR_WIDTH-1:0] reqAddr1,
    input  logic [BIT_WIDTH-1:0]  reqData1,
    output logic                  reqReady1,
    input  logic                  resvEn,
    input  logic [ADDR_WIDTH-1:0] resvAddr,
    output logic                  writeEn,
    output logic [ADDR_WIDTH-1:0] writeAddr,
    output logic [BIT_WIDTH-1:0]  writeData,
    output logic [NREG-1:0]       busyMask,
    output logic                  resvConflict
);

    // rrPtr = 0: req0 wins a tie; rrPtr = 1: req1 wins a tie.
    logic                  rrPtr;
    logic                  fire;
    logic [ADDR_WIDTH-1:0] winAddr;
    logic [BIT_WIDTH-1:0]  winData;

    // Grants depend only on valids and the pointer, so at most one is high.
    always_comb begin
        reqReady0 = reqValid0 && (!reqValid1 || !rrPtr);
        reqReady1 = reqValid1 && (!reqValid0 ||  rrPtr);
        fire      = reqReady0 || reqReady1;
        winAddr   = reqReady1 ? reqAddr1 : reqAddr0;
        winData   = reqReady1 ? reqData1 : reqData0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rrPtr     <= 1'b0;
            writeEn   <= 1'b0;
            writeAddr <= '0;
            writeData <= '0;
        end else begin
            writeEn <= fire && (winAddr != '0);
            if (fire) begin
                rrPtr     <= reqReady0;   // point at the requester that did not win
                writeAddr <= winAddr;
                writeData <= winData;
            end
        end
    end

    // Scoreboard. A bit clears on the edge the bank actually writes, so it
    // drops exactly when the data becomes visible. A same-edge reservation
    // of that register wins over the clear.
    logic [NREG-1:0] setVec;
    logic [NREG-1:0] clrVec;

    always_comb begin
        setVec = '0;
        clrVec = '0;
        if (resvEn)  setVec[resvAddr]  = 1'b1;
        if (writeEn) clrVec[writeAddr] = 1'b1;
        setVec[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busyMask <= '0;
        end else begin
            busyMask <= ((busyMask & ~clrVec) | setVec) & ~NREG'(1);
        end
    end

    // A reservation onto a register still pending (and not being written
    // this edge) means two producers overlap; flag it for one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resvConflict <= 1'b0;
        end else begin
            resvConflict <= resvEn && (resvAddr != '0) && busyMask[resvAddr]
                            && !clrVec[resvAddr];
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;

    localparam int BW = 32;
    localparam int AW = 5;
    localparam int NR = 2 ** AW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          reqValid0, reqValid1, resvEn;
    logic [AW-1:0] reqAddr0, reqAddr1, resvAddr;
    logic [BW-1:0] reqData0, reqData1;
    logic          reqReady0, reqReady1;
    logic          writeEn, resvConflict;
    logic [AW-1:0] writeAddr;
    logic [BW-1:0] writeData;
    logic [NR-1:0] busyMask;

    int checks   = 0;
    int failures = 0;

    regfile_write_arbiter #(.BIT_WIDTH(BW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .reqValid0(reqValid0), .reqAddr0(reqAddr0), .reqData0(reqData0), .reqReady0(reqReady0),
        .reqValid1(reqValid1), .reqAddr1(reqAddr1), .reqData1(reqData1), .reqReady1(reqReady1),
        .resvEn(resvEn), .resvAddr(resvAddr),
        .writeEn(writeEn), .writeAddr(writeAddr), .writeData(writeData),
        .busyMask(busyMask), .resvConflict(resvConflict)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        reqValid0 = 0; reqAddr0 = '0; reqData0 = '0;
        reqValid1 = 0; reqAddr1 = '0; reqData1 = '0;
        resvEn = 0; resvAddr = '0;
        repeat (3) step();
        chk("rst_writeEn", 64'(writeEn), 64'd0);
        chk("rst_writeAddr", 64'(writeAddr), 64'd0);
        chk("rst_writeData", 64'(writeData), 64'd0);
        chk("rst_busyMask", 64'(busyMask), 64'd0);
        chk("rst_conflict", 64'(resvConflict), 64'd0);
        rst_n = 1'b1;
        step();

        // single source
        reqValid0 = 1; reqAddr0 = 5'd5; reqData0 = 32'hDEADBEEF;
        #1;
        chk("single_ready0", 64'(reqReady0), 64'd1);
        chk("single_ready1", 64'(reqReady1), 64'd0);
        step();
        reqValid0 = 0;
        chk("single_writeEn", 64'(writeEn), 64'd1);
        chk("single_writeAddr", 64'(writeAddr), 64'd5);
        chk("single_writeData", 64'(writeData), 64'hDEADBEEF);

        // reset mid-transfer: pointer now favours req1, reserve r6, write r6
        reqValid1 = 1; reqAddr1 = 5'd6; reqData1 = 32'h66;
        resvEn = 1; resvAddr = 5'd6;
        step();
        reqValid1 = 0; resvEn = 0;
        chk("mid_writeEn", 64'(writeEn), 64'd1);
        chk("mid_busy", 64'(busyMask), 64'(1) << 6);
        #2 rst_n = 1'b0;
        #1;
        chk("async_writeEn", 64'(writeEn), 64'd0);
        chk("async_busyMask", 64'(busyMask), 64'd0);
        step();
        rst_n = 1'b1;
        step();

        // contention: grants alternate 0,1,0,1 starting at req0
        reqValid0 = 1; reqAddr0 = 5'd3; reqData0 = 32'hA3;
        reqValid1 = 1; reqAddr1 = 5'd7; reqData1 = 32'hB7;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("cont_ready0_%0d", i), 64'(reqReady0), 64'((i % 2) == 0));
            chk($sformatf("cont_ready1_%0d", i), 64'(reqReady1), 64'((i % 2) == 1));
            step();
            chk($sformatf("cont_writeAddr_%0d", i), 64'(writeAddr), (i % 2) == 0 ? 64'd3 : 64'd7);
            chk($sformatf("cont_writeData_%0d", i), 64'(writeData), (i % 2) == 0 ? 64'hA3 : 64'hB7);
            chk($sformatf("cont_writeEn_%0d", i), 64'(writeEn), 64'd1);
        end
        reqValid0 = 0; reqValid1 = 0;

        // x0 write from req1
        reqValid1 = 1; reqAddr1 = 5'd0; reqData1 = 32'hFFFFFFFF;
        #1;
        chk("x0_ready1", 64'(reqReady1), 64'd1);
        step();
        chk("x0_writeEn", 64'(writeEn), 64'd0);
        reqValid0 = 1; reqAddr0 = 5'd1;
        #1;
        chk("x0_rr_ready0", 64'(reqReady0), 64'd1);
        chk("x0_rr_ready1", 64'(reqReady1), 64'd0);
        reqValid0 = 0; reqValid1 = 0;
        step();

        // scoreboard
        resvEn = 1; resvAddr = 5'd9;
        step();
        resvEn = 0;
        chk("sb_set9", 64'(busyMask), 64'(1) << 9);
        reqValid0 = 1; reqAddr0 = 5'd9; reqData0 = 32'h99;
        step();
        reqValid0 = 0;
        chk("sb_write9_en", 64'(writeEn), 64'd1);
        chk("sb_busy_before_clear", 64'(busyMask), 64'(1) << 9);
        resvEn = 1; resvAddr = 5'd9;   // same edge as the clear
        step();
        resvEn = 0;
        chk("sb_setwins", 64'(busyMask), 64'(1) << 9);
        chk("sb_setwins_noconf", 64'(resvConflict), 64'd0);
        reqValid0 = 1;
        step();
        reqValid0 = 0;
        chk("sb_write9b_en", 64'(writeEn), 64'd1);
        step();
        chk("sb_cleared", 64'(busyMask), 64'd0);

        // reservation of x0 is ignored
        resvEn = 1; resvAddr = 5'd0;
        step();
        resvEn = 0;
        chk("resv0_busy", 64'(busyMask), 64'd0);
        chk("resv0_conf", 64'(resvConflict), 64'd0);

        // conflict
        resvEn = 1; resvAddr = 5'd4;
        step();
        chk("conf_first_busy", 64'(busyMask), 64'(1) << 4);
        chk("conf_first_flag", 64'(resvConflict), 64'd0);
        step();
        resvEn = 0;
        chk("conf_flag", 64'(resvConflict), 64'd1);
        chk("conf_busy", 64'(busyMask), 64'(1) << 4);
        step();
        chk("conf_pulse_end", 64'(resvConflict), 64'd0);
        chk("conf_busy_hold", 64'(busyMask), 64'(1) << 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
